vga_rx: RTL
===========

# vga_rx

Receive-side VGA timing recovery block: the sink end of the sync/pixel interface driven by the `hvsync`-based pattern generator. It samples incoming `hsync`/`vsync`/RGB synchronously on the 25 MHz pixel clock and rebuilds pixel coordinates from the sync edges. It measures line and frame lengths and declares lock once the measured timing matches the 640x480 format. Downstream capture/checker logic consumes its aligned pixel stream plus `hpos`/`vpos`.

## Interface
- `H_ACTIVE` = 640: visible pixels per line
- `H_SYNC` = 96: hsync width, clocks
- `H_BACK` = 48: back porch, clocks
- `H_TOTAL` = 800: expected clocks per line
- `V_ACTIVE` = 480: visible lines
- `V_SYNC` = 2, `V_BACK` = 33: vsync width / back porch, lines
- `V_TOTAL` = 525: expected lines per frame
- `SYNC_POL` = 0: asserted level of both sync inputs (0 = active-low)
- `LOCK_FRAMES` = 2: consecutive good frames required for lock
- `clk`  input  1  pixel clock; all inputs synchronous to it
- `reset`  input  1  asynchronous, active-low reset
- `hsync_in`, `vsync_in`  input  1 each  incoming syncs
- `rgb_in`  input  12  incoming pixel {R,G,B}, 4 bits each
- `rgb_out`  output  12  pixel aligned with `hpos`/`vpos`
- `hpos`, `vpos`  output  10 each  active-area coordinates
- `display_on`  output  1  `rgb_out` is a valid active pixel
- `locked`  output  1  timing matches parameters
- `frame_start`  output  1  one-cycle pulse at each frame boundary while locked
- `h_meas`, `v_meas`  output  10 each  last measured line length (clocks) / frame length (lines)

## Operation
- Input stage: `hsync_in`, `vsync_in`, `rgb_in` registered once (`hs_q`, `vs_q`, `rgb_q`); second register on each of hs/vs for edge detect. `h_lead` = `hs_q` asserted and previous not; `v_lead` likewise.
- Horizontal counter `hcnt` (10 b): `h_lead` -> 0, else +1 saturating at 1023. On `h_lead`: `h_meas` <= `hcnt`+1; `line_ok` = (`hcnt`+1 == `H_TOTAL`).
- `v_lead` sets `v_pend`. Frame boundary = `h_lead` with `v_pend` set, or `h_lead` and `v_lead` in the same cycle. At boundary: `vcnt` <= 0, `v_meas` <= `vcnt`+1, `v_pend` cleared. Other `h_lead`: `vcnt` +1, saturating at 1023.
- `bad` flag: set on `h_lead` with !`line_ok`; cleared at each boundary after evaluation. `frame_ok` = (`vcnt`+1 == `V_TOTAL`) and !`bad` and current line ok.
- FSM `SEARCH`, `TRACK`, `LOCKED`; `good` counter cleared on entering `TRACK`.
  - SEARCH: first boundary -> TRACK.
  - TRACK: boundary with `frame_ok`: `good`+1; on reaching `LOCK_FRAMES` -> LOCKED. Boundary with !`frame_ok`: `good` <= 0, stay.
  - LOCKED: `h_lead` with !`line_ok`, boundary with !`frame_ok`, or `hcnt` reaching 1023 -> SEARCH.
  - `hcnt` reaching 1023 in TRACK -> SEARCH.
- Active window: `hcnt` in [`H_SYNC`+`H_BACK`, +`H_ACTIVE`) and `vcnt` in [`V_SYNC`+`V_BACK`, +`V_ACTIVE`). `display_on` = window and `locked`. `hpos` = `hcnt`-(`H_SYNC`+`H_BACK`) and `vpos` = `vcnt`-(`V_SYNC`+`V_BACK`) when `display_on`, else 0. `rgb_out` = 0 when !`display_on`.
- `locked` = (state == LOCKED). `frame_start` pulses for one cycle after a boundary that leaves the state in LOCKED, including the boundary that enters lock.
- All outputs are registered or decoded from registers only. There is no combinational path from input to output.

## Timing
- Reset (async assert, sync release): state SEARCH, counters, `v_pend`, `bad`, `good`, `h_meas`, `v_meas` = 0. All outputs 0.
- Let t0 be the edge that first samples asserted `hsync_in`. Then `hcnt` = 0 after t0+1.
- `rgb_in` sampled at t0+k appears on `rgb_out` after t0+k+1, with `hcnt` = k. Pixel latency is 2 clocks.
- `locked` falls the clock after the failing `h_lead`, boundary, or saturation. `display_on` falls with it.
- Reset mid-frame: everything returns to reset values. A full re-acquisition is required.

## Test plan
- Reset held low with syncs toggling -> all outputs 0. After release, `locked`=0 until the third frame boundary.
- Nominal 640x480 stream, pixel = {hpos[3:0], vpos[3:0], 4'hA} -> `locked`=1 at the 3rd boundary, `frame_start` 1 cycle. Pixel (5,7) appears with `hpos`=5, `vpos`=7, `display_on`=1, 2 clocks after input. `h_meas`=800, `v_meas`=525.
- While locked, inject one 799-clock line -> `locked`=0 next clock, `h_meas`=799. Relock needs 2 full good frames after the next boundary.
- While locked, stop `hsync_in` -> `locked`=0 when `hcnt` hits 1023; `hpos`/`vpos`/`rgb_out` = 0.
- `vsync_in` edge coincident with `hsync_in` edge vs. 10 clocks before -> both give boundary on that `h_lead`, `vcnt`=0, `v_meas`=525.
- Assert `reset` mid-active-line while locked -> outputs 0 immediately. Lock regained after 3 boundaries.

Source files
------------

// File: rtl/vga_rx.sv
// VGA receive-side timing recovery: rebuilds pixel coordinates from incoming
// syncs, measures line/frame lengths and declares lock on a matching format.
module vga_rx #(
  parameter int   H_ACTIVE    = 640,
  parameter int   H_SYNC      = 96,
  parameter int   H_BACK      = 48,
  parameter int   H_TOTAL     = 800,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_SYNC      = 2,
  parameter int   V_BACK      = 33,
  parameter int   V_TOTAL     = 525,
  parameter logic SYNC_POL    = 1'b0,
  parameter int   LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [11:0] rgb_in,
  output logic [11:0] rgb_out,
  output logic [9:0]  hpos,
  output logic [9:0]  vpos,
  output logic        display_on,
  output logic        locked,
  output logic        frame_start,
  output logic [9:0]  h_meas,
  output logic [9:0]  v_meas
);

  localparam logic [9:0] H_START = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_END   = 10'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0] V_START = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_END   = 10'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [9:0] H_TOT   = 10'(H_TOTAL);
  localparam logic [9:0] V_TOT   = 10'(V_TOTAL);
  localparam logic [9:0] CNT_MAX = 10'h3FF;
  localparam logic [3:0] GOOD_TGT = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  state_t      state_q, state_d;
  logic        hs_q, hs_d, hs_prev_q, hs_prev_d;
  logic        vs_q, vs_d, vs_prev_q, vs_prev_d;
  logic [11:0] rgb_q, rgb_d, pix_q, pix_d;
  logic [9:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [9:0]  h_meas_q, h_meas_d, v_meas_q, v_meas_d;
  logic        v_pend_q, v_pend_d;
  logic        bad_q, bad_d;
  logic [3:0]  good_q, good_d;
  logic        frame_start_q, frame_start_d;

  logic        h_lead, v_lead, boundary, line_ok, frame_ok, hcnt_sat;
  logic [9:0]  hcnt_inc, vcnt_inc;
  logic [3:0]  good_inc;
  logic        h_win, v_win;

  always_comb begin
    hs_d      = hsync_in;
    vs_d      = vsync_in;
    rgb_d     = rgb_in;
    hs_prev_d = hs_q;
    vs_prev_d = vs_q;
    pix_d     = rgb_q;

    h_lead   = (hs_q == SYNC_POL) && (hs_prev_q != SYNC_POL);
    v_lead   = (vs_q == SYNC_POL) && (vs_prev_q != SYNC_POL);
    hcnt_inc = hcnt_q + 10'd1;
    vcnt_inc = vcnt_q + 10'd1;
    good_inc = good_q + 4'd1;
    line_ok  = (hcnt_inc == H_TOT);
    boundary = h_lead && (v_pend_q || v_lead);
    frame_ok = (vcnt_inc == V_TOT) && !bad_q && line_ok;

    hcnt_d   = hcnt_q;
    vcnt_d   = vcnt_q;
    h_meas_d = h_meas_q;
    v_meas_d = v_meas_q;
    v_pend_d = v_pend_q;
    bad_d    = bad_q;

    if (h_lead) begin
      hcnt_d   = '0;
      h_meas_d = hcnt_inc;
    end else if (hcnt_q != CNT_MAX) begin
      hcnt_d = hcnt_inc;
    end
    hcnt_sat = (hcnt_d == CNT_MAX);

    // A vsync lead may precede its hsync lead; v_pend carries it to the line start.
    if (boundary) begin
      vcnt_d   = '0;
      v_meas_d = vcnt_inc;
      v_pend_d = 1'b0;
      bad_d    = 1'b0;
    end else begin
      if (v_lead) v_pend_d = 1'b1;
      if (h_lead) begin
        if (vcnt_q != CNT_MAX) vcnt_d = vcnt_inc;
        if (!line_ok) bad_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    case (state_q)
      SEARCH: begin
        if (boundary) begin
          state_d = TRACK;
          good_d  = '0;
        end
      end
      TRACK: begin
        if (hcnt_sat) begin
          state_d = SEARCH;
        end else if (boundary) begin
          if (frame_ok) begin
            good_d = good_inc;
            if (good_inc >= GOOD_TGT) state_d = LOCKED;
          end else begin
            good_d = '0;
          end
        end
      end
      LOCKED: begin
        if ((h_lead && !line_ok) || (boundary && !frame_ok) || hcnt_sat)
          state_d = SEARCH;
      end
      default: state_d = SEARCH;
    endcase
    frame_start_d = boundary && (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= SEARCH;
      hs_q          <= ~SYNC_POL;
      hs_prev_q     <= ~SYNC_POL;
      vs_q          <= ~SYNC_POL;
      vs_prev_q     <= ~SYNC_POL;
      rgb_q         <= '0;
      pix_q         <= '0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      h_meas_q      <= '0;
      v_meas_q      <= '0;
      v_pend_q      <= 1'b0;
      bad_q         <= 1'b0;
      good_q        <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hs_q          <= hs_d;
      hs_prev_q     <= hs_prev_d;
      vs_q          <= vs_d;
      vs_prev_q     <= vs_prev_d;
      rgb_q         <= rgb_d;
      pix_q         <= pix_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      h_meas_q      <= h_meas_d;
      v_meas_q      <= v_meas_d;
      v_pend_q      <= v_pend_d;
      bad_q         <= bad_d;
      good_q        <= good_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Outputs decode registered state only; pix_q lines up with hcnt_q/vcnt_q.
  always_comb begin
    h_win       = (hcnt_q >= H_START) && (hcnt_q < H_END);
    v_win       = (vcnt_q >= V_START) && (vcnt_q < V_END);
    locked      = (state_q == LOCKED);
    display_on  = h_win && v_win && locked;
    hpos        = display_on ? (hcnt_q - H_START) : '0;
    vpos        = display_on ? (vcnt_q - V_START) : '0;
    rgb_out     = display_on ? pix_q : '0;
    frame_start = frame_start_q;
    h_meas      = h_meas_q;
    v_meas      = v_meas_q;
  end

endmodule
